// File: rtl/booth_mul_pipe.sv
// Two-stage radix-4 Booth multiplier with carry-save reduction.
// Stage 1 registers the reduced sum/carry pair; stage 2 registers the final
// product. Valid/ready on both sides, plus a flush that drops everything held.
// WIDTH must be even and at least 4.
module booth_mul_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic                 mul_clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_result,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned EW  = WIDTH + 2;
  localparam int unsigned NPP = WIDTH / 2 + 1;

  logic             fill_a;
  logic             fill_b;
  logic [PW-1:0]    a_pos;
  logic [PW-1:0]    a_neg;
  logic [PW-1:0]    a2_pos;
  logic [PW-1:0]    a2_neg;
  logic [EW:0]      b_pad;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    cs_sum;
  logic [PW-1:0]    cs_carry;
  logic [PW-1:0]    nx_sum;
  logic [PW-1:0]    nx_carry;

  logic             s1_valid;
  logic [PW-1:0]    s1_sum;
  logic [PW-1:0]    s1_carry;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_free;
  logic             s1_adv;
  logic             accept;
  logic             load_out;

  // Handshake: S2 can take a new result when empty or being drained this cycle.
  assign s2_free  = ~out_valid | out_ready;
  assign s1_adv   = s1_valid & s2_free;
  assign in_ready = ~flush & (~s1_valid | s2_free);
  assign accept   = in_valid & in_ready;
  assign load_out = s1_adv & ~flush;

  // Booth recoding of the extended multiplier and 3:2 carry-save reduction.
  always_comb begin
    fill_a   = in_a[WIDTH-1] & in_signed;
    fill_b   = in_b[WIDTH-1] & in_signed;
    a_pos    = {{WIDTH{fill_a}}, in_a};
    a_neg    = ~a_pos + PW'(1);
    a2_pos   = a_pos << 1;
    a2_neg   = ~a2_pos + PW'(1);
    b_pad    = {fill_b, fill_b, in_b, 1'b0};
    pp       = '0;
    cs_sum   = '0;
    cs_carry = '0;
    nx_sum   = '0;
    nx_carry = '0;
    for (int i = 0; i < int'(NPP); i++) begin
      case (b_pad[2*i +: 3])
        3'b001, 3'b010: pp = a_pos;
        3'b011:         pp = a2_pos;
        3'b100:         pp = a2_neg;
        3'b101, 3'b110: pp = a_neg;
        default:        pp = '0;
      endcase
      pp = pp << (2 * i);
      if (i == 0) begin
        cs_sum = pp;
      end else if (i == 1) begin
        cs_carry = pp;
      end else begin
        nx_sum   = cs_sum ^ cs_carry ^ pp;
        nx_carry = ((cs_sum & cs_carry) | (cs_sum & pp) | (cs_carry & pp)) << 1;
        cs_sum   = nx_sum;
        cs_carry = nx_carry;
      end
    end
  end

  // Stage-1 and output occupancy; flush empties both at the next edge.
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept)      s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;
      if (s1_adv)         out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

  // Stage-1 data loads only on an accepted operation.
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      s1_sum   <= '0;
      s1_carry <= '0;
      s1_tag   <= '0;
    end else if (accept) begin
      s1_sum   <= cs_sum;
      s1_carry <= cs_carry;
      s1_tag   <= in_tag;
    end
  end

  // Output data resolves the carry-save pair when stage 1 advances.
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      out_result <= '0;
      out_tag    <= '0;
    end else if (load_out) begin
      out_result <= s1_sum + s1_carry;
      out_tag    <= s1_tag;
    end
  end

endmodule

// File: tb/tb_booth_mul_pipe.sv
// Bench for booth_mul_pipe: directed corner vectors and pipeline sequences on
// a 32-bit instance, then random traffic on 32/16/8-bit instances against an
// arithmetic product model.
module tb_booth_mul_pipe;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
  } exp_t;

  logic        mul_clk;
  logic        reset;
  logic        flush;
  logic        in_valid  [3];
  logic        rdy       [3];
  logic        in_signed [3];
  logic [31:0] in_a      [3];
  logic [31:0] in_b      [3];
  logic [4:0]  in_tag    [3];
  logic        ov        [3];
  logic        out_ready [3];
  logic [4:0]  otag      [3];
  logic [63:0] res32;
  logic [31:0] res16;
  logic [15:0] res8;

  int   total = 0;
  int   bad   = 0;
  int   wd    [3];
  logic [4:0] tag_ctr [3];
  exp_t q [3][$];
  vec_t tbl [8];

  booth_mul_pipe #(.WIDTH(32), .TAG_W(5)) dut32 (
    .mul_clk(mul_clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(rdy[0]),
    .in_signed(in_signed[0]), .in_a(in_a[0]), .in_b(in_b[0]), .in_tag(in_tag[0]),
    .flush(flush), .out_valid(ov[0]), .out_ready(out_ready[0]),
    .out_result(res32), .out_tag(otag[0]));

  booth_mul_pipe #(.WIDTH(16), .TAG_W(5)) dut16 (
    .mul_clk(mul_clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(rdy[1]),
    .in_signed(in_signed[1]), .in_a(in_a[1][15:0]), .in_b(in_b[1][15:0]), .in_tag(in_tag[1]),
    .flush(flush), .out_valid(ov[1]), .out_ready(out_ready[1]),
    .out_result(res16), .out_tag(otag[1]));

  booth_mul_pipe #(.WIDTH(8), .TAG_W(5)) dut8 (
    .mul_clk(mul_clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(rdy[2]),
    .in_signed(in_signed[2]), .in_a(in_a[2][7:0]), .in_b(in_b[2][7:0]), .in_tag(in_tag[2]),
    .flush(flush), .out_valid(ov[2]), .out_ready(out_ready[2]),
    .out_result(res8), .out_tag(otag[2]));

  initial mul_clk = 1'b0;
  always #5 mul_clk = ~mul_clk;

  function automatic logic [63:0] get_res(input int k);
    case (k)
      0:       return res32;
      1:       return 64'(res16);
      default: return 64'(res8);
    endcase
  endfunction

  // Reference product of two w-bit operands, truncated to 2w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic sgn,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0] p;
    sa = $signed(64'(a));
    sb = $signed(64'(b));
    if (sgn) begin
      sa = (sa <<< (64 - w)) >>> (64 - w);
      sb = (sb <<< (64 - w)) >>> (64 - w);
    end
    p = 64'(sa * sb);
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  function automatic logic [31:0] rand_opnd(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return m;
      2:       return 32'd1 << (w - 1);
      3:       return (32'd1 << (w - 1)) - 32'd1;
      default: return $urandom() & m;
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge mul_clk);
    @(negedge mul_clk);
  endtask

  task automatic drive0(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
    in_valid[0]  = 1'b1;
    in_signed[0] = sgn;
    in_a[0]      = a;
    in_b[0]      = b;
    in_tag[0]    = tag;
  endtask

  // One random-traffic cycle on all three instances; active=0 just drains.
  task automatic rand_cycle(input bit active);
    exp_t e;
    @(negedge mul_clk);
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = active && ($urandom_range(0, 3) != 0);
      in_signed[k] = 1'($urandom_range(0, 1));
      in_a[k]      = rand_opnd(wd[k]);
      in_b[k]      = rand_opnd(wd[k]);
      in_tag[k]    = tag_ctr[k];
      out_ready[k] = active ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      if (ov[k] && out_ready[k]) begin
        if (q[k].size() == 0) begin
          check($sformatf("rnd_extra_w%0d", wd[k]), 64'(otag[k]), 64'hDEAD);
        end else begin
          e = q[k].pop_front();
          check($sformatf("rnd_res_w%0d", wd[k]), get_res(k), e.res);
          check($sformatf("rnd_tag_w%0d", wd[k]), 64'(otag[k]), 64'(e.tag));
        end
      end
      if (in_valid[k] && rdy[k]) begin
        e.res = ref_mul(wd[k], in_signed[k], in_a[k], in_b[k]);
        e.tag = tag_ctr[k];
        q[k].push_back(e);
        tag_ctr[k] = tag_ctr[k] + 5'd1;
      end
    end
  endtask

  initial begin : main
    logic [31:0] ba [4];
    logic [31:0] bb [4];
    logic [63:0] be [4];

    wd[0] = 32; wd[1] = 16; wd[2] = 8;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_signed[k] = 1'b0; in_a[k] = '0; in_b[k] = '0;
      in_tag[k] = '0; out_ready[k] = 1'b1; tag_ctr[k] = '0;
    end
    flush = 1'b0;
    reset = 1'b1;

    tbl[0] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 64'h0000_0000_0000_0001};
    tbl[1] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 5'd2, 64'hFFFF_FFFF_8000_0000};
    tbl[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 5'd3, 64'h4000_0000_0000_0000};
    tbl[3] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 64'hFFFF_FFFE_0000_0001};
    tbl[4] = '{1'b0, 32'h0000_0000, 32'h1234_5678, 5'd5, 64'h0000_0000_0000_0000};
    tbl[5] = '{1'b1, 32'h0000_0003, 32'hFFFF_FFFB, 5'd6, 64'hFFFF_FFFF_FFFF_FFF1};
    tbl[6] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0002, 5'd7, 64'h0000_0000_FFFF_FFFE};
    tbl[7] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd8, 64'h3FFF_FFFF_0000_0001};

    // Reset state.
    @(negedge mul_clk);
    @(negedge mul_clk);
    #1;
    check("rst_valid", 64'(ov[0]), 64'd0);
    check("rst_result", res32, 64'd0);
    check("rst_tag", 64'(otag[0]), 64'd0);
    reset = 1'b0;
    #1;
    check("rst_ready", 64'(rdy[0]), 64'd1);

    // Directed vectors: accept, no result after one edge, result after two.
    for (int i = 0; i < 8; i++) begin
      cyc();
      drive0(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].tag);
      #1 check($sformatf("tbl%0d_ready", i), 64'(rdy[0]), 64'd1);
      cyc();
      in_valid[0] = 1'b0;
      #1 check($sformatf("tbl%0d_early", i), 64'(ov[0]), 64'd0);
      cyc();
      #1;
      check($sformatf("tbl%0d_valid", i), 64'(ov[0]), 64'd1);
      check($sformatf("tbl%0d_result", i), res32, tbl[i].exp);
      check($sformatf("tbl%0d_tag", i), 64'(otag[0]), 64'(tbl[i].tag));
    end

    // Back-to-back issue under backpressure, then release.
    for (int i = 0; i < 4; i++) begin
      ba[i] = $urandom();
      bb[i] = $urandom();
      be[i] = ref_mul(32, 1'b1, ba[i], bb[i]);
    end
    cyc();
    out_ready[0] = 1'b0;
    drive0(1'b1, ba[0], bb[0], 5'd10);
    #1 check("bp_rdy0", 64'(rdy[0]), 64'd1);
    cyc();
    drive0(1'b1, ba[1], bb[1], 5'd11);
    #1 check("bp_rdy1", 64'(rdy[0]), 64'd1);
    cyc();
    drive0(1'b1, ba[2], bb[2], 5'd12);
    #1;
    check("bp_stall_a", 64'(rdy[0]), 64'd0);
    check("bp_hold_a", res32, be[0]);
    cyc();
    #1;
    check("bp_stall_b", 64'(rdy[0]), 64'd0);
    check("bp_hold_b", res32, be[0]);
    check("bp_hold_tag", 64'(otag[0]), 64'd10);
    cyc();
    out_ready[0] = 1'b1;
    #1;
    check("bp_rel_rdy", 64'(rdy[0]), 64'd1);
    check("bp_out1", res32, be[0]);
    check("bp_v1", 64'(ov[0]), 64'd1);
    cyc();
    drive0(1'b1, ba[3], bb[3], 5'd13);
    #1;
    check("bp_out2", res32, be[1]);
    check("bp_tag2", 64'(otag[0]), 64'd11);
    cyc();
    in_valid[0] = 1'b0;
    #1;
    check("bp_out3", res32, be[2]);
    check("bp_v3", 64'(ov[0]), 64'd1);
    cyc();
    #1;
    check("bp_out4", res32, be[3]);
    check("bp_tag4", 64'(otag[0]), 64'd13);
    cyc();
    #1 check("bp_drained", 64'(ov[0]), 64'd0);

    // Flush with two in flight and a new offer in the same cycle.
    out_ready[0] = 1'b0;
    drive0(1'b0, 32'd5, 32'd6, 5'd20);
    cyc();
    drive0(1'b0, 32'd7, 32'd8, 5'd21);
    cyc();
    drive0(1'b0, 32'd9, 32'd10, 5'd22);
    flush = 1'b1;
    #1;
    check("fl_full", 64'(ov[0]), 64'd1);
    check("fl_rdy", 64'(rdy[0]), 64'd0);
    cyc();
    flush = 1'b0;
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    #1 check("fl_gone", 64'(ov[0]), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1 check("fl_quiet", 64'(ov[0]), 64'd0);
    end
    drive0(1'b1, 32'hFFFF_FFFE, 32'd3, 5'd23);
    cyc();
    in_valid[0] = 1'b0;
    cyc();
    #1;
    check("fl_after_v", 64'(ov[0]), 64'd1);
    check("fl_after_res", res32, 64'hFFFF_FFFF_FFFF_FFFA);
    check("fl_after_tag", 64'(otag[0]), 64'd23);
    cyc();

    // Asynchronous reset with both stages occupied.
    out_ready[0] = 1'b0;
    drive0(1'b0, 32'd11, 32'd12, 5'd24);
    cyc();
    drive0(1'b0, 32'd13, 32'd14, 5'd25);
    cyc();
    in_valid[0] = 1'b0;
    #1 check("mr_full", 64'(ov[0]), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("mr_valid", 64'(ov[0]), 64'd0);
    check("mr_result", res32, 64'd0);
    check("mr_tag", 64'(otag[0]), 64'd0);
    cyc();
    reset = 1'b0;
    out_ready[0] = 1'b1;
    #1;
    check("mr_ready", 64'(rdy[0]), 64'd1);
    cyc();
    #1 check("mr_nothing", 64'(ov[0]), 64'd0);

    // Random traffic on all widths, then drain.
    for (int c = 0; c < 5000; c++) rand_cycle(1'b1);
    for (int c = 0; c < 6; c++) rand_cycle(1'b0);
    for (int k = 0; k < 3; k++)
      check($sformatf("rnd_left_w%0d", wd[k]), 64'(q[k].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
